// File: rtl/ili9341_init_ctrl_pkg.sv
// rtl/ili9341_init_ctrl_pkg.sv - shared types and constants for the ILI9341 init controller
package pkg_ili9341;

   typedef enum logic [1:0] {
      ENT_CMD   = 2'd0,
      ENT_DATA  = 2'd1,
      ENT_DELAY = 2'd2,
      ENT_END   = 2'd3
   } entry_type_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RST_REQ,
      ST_RST_WAIT,
      ST_FETCH,
      ST_SEND,
      ST_DELAY,
      ST_DONE
   } state_t;

   localparam logic HIGH = 1'b1;
   localparam logic LOW  = 1'b0;
   localparam logic ON   = 1'b1;
   localparam logic OFF  = 1'b0;

   function automatic logic [9:0] rom_entry(entry_type_t kind, logic [7:0] payload);
      return {kind, payload};
   endfunction

endpackage

// File: rtl/ili9341_init_ctrl_if.sv
// rtl/ili9341_init_ctrl_if.sv - byte stream from the init controller to the SPI byte sender
interface ili9341_init_ctrl_if;
   logic       o_tx_valid;
   logic [7:0] o_tx_byte;
   logic       o_tx_dc;
   logic       i_tx_ready;

   modport master (output o_tx_valid, output o_tx_byte, output o_tx_dc, input  i_tx_ready);
   modport slave  (input  o_tx_valid, input  o_tx_byte, input  o_tx_dc, output i_tx_ready);
endinterface

// File: rtl/ili9341_init_ctrl_rom.sv
// rtl/ili9341_init_ctrl_rom.sv - combinational init table; entries past ROM_DEPTH read as END
module ili9341_init_rom
   import pkg_ili9341::*;
#(
   parameter int ROM_DEPTH = 64,
   parameter int TABLE_SEL = 0,
   parameter int IDX_W     = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1
) (
   input  logic [IDX_W-1:0] index,
   output logic [9:0]       entry
);

   int unsigned addr;

   always_comb begin
      addr  = 32'(index);
      entry = rom_entry(ENT_END, 8'h00);
      if (TABLE_SEL == 0) begin
         // Power-on table: SWRESET, SLPOUT, 16-bit pixels, MADCTL, DISPON
         case (addr)
            0:       entry = rom_entry(ENT_CMD,   8'h01);
            1:       entry = rom_entry(ENT_DELAY, 8'd5);
            2:       entry = rom_entry(ENT_CMD,   8'h11);
            3:       entry = rom_entry(ENT_DELAY, 8'd120);
            4:       entry = rom_entry(ENT_CMD,   8'h3A);
            5:       entry = rom_entry(ENT_DATA,  8'h55);
            6:       entry = rom_entry(ENT_CMD,   8'h36);
            7:       entry = rom_entry(ENT_DATA,  8'h48);
            8:       entry = rom_entry(ENT_CMD,   8'h29);
            default: entry = rom_entry(ENT_END,   8'h00);
         endcase
      end else begin
         // Short table exercising both delay corners and a CMD/DATA pair
         case (addr)
            0:       entry = rom_entry(ENT_CMD,   8'h01);
            1:       entry = rom_entry(ENT_DELAY, 8'd3);
            2:       entry = rom_entry(ENT_CMD,   8'h11);
            3:       entry = rom_entry(ENT_DELAY, 8'd0);
            4:       entry = rom_entry(ENT_CMD,   8'h3A);
            5:       entry = rom_entry(ENT_DATA,  8'h55);
            default: entry = rom_entry(ENT_END,   8'h00);
         endcase
      end
      if (addr >= 32'(ROM_DEPTH)) begin
         entry = rom_entry(ENT_END, 8'h00);
      end
   end

endmodule

// File: rtl/ili9341_init_ctrl.sv
// rtl/ili9341_init_ctrl.sv - walks the init ROM: panel reset, command/data bytes, millisecond delays
module ili9341_init_ctrl
   import pkg_ili9341::*;
#(
   parameter int CLK_PER_MS = 125_000,
   parameter int ROM_DEPTH  = 64,
   parameter int TABLE_SEL  = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_start,
   output logic                       o_busy,
   output logic                       o_done,
   output logic                       o_reset_ena,
   output logic                       o_reset_val,
   input  logic                       i_reset_sent,
   ili9341_init_ctrl_if.master        tx
);

   localparam int IDX_W = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;
   localparam int CNT_W = $clog2(255 * CLK_PER_MS + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROM_DEPTH - 1);

   state_t           state, state_n;
   logic [IDX_W-1:0] idx, idx_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [7:0]       pay, pay_n;
   logic             dc, dc_n;
   logic [9:0]       entry;
   entry_type_t      ent_type;
   logic             step;

   ili9341_init_rom #(
      .ROM_DEPTH (ROM_DEPTH),
      .TABLE_SEL (TABLE_SEL),
      .IDX_W     (IDX_W)
   ) u_rom (
      .index (idx),
      .entry (entry)
   );

   assign ent_type = entry_type_t'(entry[9:8]);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
         idx   <= '0;
         cnt   <= '0;
         pay   <= 8'h00;
         dc    <= LOW;
      end else begin
         state <= state_n;
         idx   <= idx_n;
         cnt   <= cnt_n;
         pay   <= pay_n;
         dc    <= dc_n;
      end
   end

   always_comb begin
      state_n = state;
      idx_n   = idx;
      cnt_n   = cnt;
      pay_n   = pay;
      dc_n    = dc;
      step    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (i_start) begin
               state_n = ST_RST_REQ;
               idx_n   = '0;
            end
         end
         ST_RST_REQ:  state_n = ST_RST_WAIT;
         ST_RST_WAIT: begin
            if (i_reset_sent) state_n = ST_FETCH;
         end
         ST_FETCH: begin
            pay_n = entry[7:0];
            case (ent_type)
               ENT_CMD: begin
                  dc_n    = LOW;
                  state_n = ST_SEND;
               end
               ENT_DATA: begin
                  dc_n    = HIGH;
                  state_n = ST_SEND;
               end
               ENT_DELAY: begin
                  cnt_n   = CNT_W'(32'(entry[7:0]) * CLK_PER_MS);
                  state_n = ST_DELAY;
               end
               default: state_n = ST_DONE;
            endcase
         end
         ST_SEND: begin
            if (tx.i_tx_ready) step = 1'b1;
         end
         ST_DELAY: begin
            // Leaving at a count of 1 gives exactly payload*CLK_PER_MS cycles; 0 still costs one cycle
            cnt_n = (cnt == '0) ? '0 : cnt - CNT_W'(1);
            if (cnt <= CNT_W'(1)) step = 1'b1;
         end
         ST_DONE: state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase
      if (step) begin
         if (idx == LAST_IDX) begin
            state_n = ST_DONE;
         end else begin
            idx_n   = idx + IDX_W'(1);
            state_n = ST_FETCH;
         end
      end
   end

   assign o_busy         = (state != ST_IDLE);
   assign o_done         = (state == ST_DONE);
   assign o_reset_ena    = (state == ST_RST_REQ) ? ON : OFF;
   assign o_reset_val    = (state == ST_IDLE) ? HIGH : LOW;
   assign tx.o_tx_valid  = (state == ST_SEND);
   assign tx.o_tx_byte   = (state == ST_SEND) ? pay : 8'h00;
   assign tx.o_tx_dc     = (state == ST_SEND) ? dc : LOW;

endmodule

// File: tb/tb_ili9341_init_ctrl.sv
// tb/tb_ili9341_init_ctrl.sv - scoreboard bench for the ILI9341 init controller
module tb_ili9341_init_ctrl;

   localparam int CPM = 4;

   logic clk   = 1'b0;
   logic rst   = 1'b0;
   logic start = 1'b0;
   logic sent  = 1'b0;
   logic ready = 1'b1;
   logic busy, done, rena, rval;
   logic busy_b, done_b, rena_b, rval_b;

   ili9341_init_ctrl_if tx_a ();
   ili9341_init_ctrl_if tx_b ();

   assign tx_a.i_tx_ready = ready;
   assign tx_b.i_tx_ready = 1'b1;

   ili9341_init_ctrl #(.CLK_PER_MS(CPM), .ROM_DEPTH(64), .TABLE_SEL(1)) dut (
      .clk(clk), .rst(rst), .i_start(start), .o_busy(busy), .o_done(done),
      .o_reset_ena(rena), .o_reset_val(rval), .i_reset_sent(sent), .tx(tx_a)
   );

   ili9341_init_ctrl #(.CLK_PER_MS(CPM), .ROM_DEPTH(3), .TABLE_SEL(1)) dut_b (
      .clk(clk), .rst(rst), .i_start(start), .o_busy(busy_b), .o_done(done_b),
      .o_reset_ena(rena_b), .o_reset_val(rval_b), .i_reset_sent(sent), .tx(tx_b)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   logic [8:0] exp_q[$];
   logic [8:0] b_q[$];
   int gap_q[$];
   int ena_cnt = 0, val_bad = 0, done_cnt = 0, gap_cnt = 0;
   int b_done = 0, b_ena = 0, b_val_bad = 0;
   logic in_gap = 1'b0, prev_done = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Scoreboard and protocol monitor for the main instance
   always @(negedge clk) begin : mon_a
      logic [8:0] e;
      if (tx_a.o_tx_valid) begin
         if (in_gap) begin
            gap_q.push_back(gap_cnt);
            in_gap = 1'b0;
         end
         if (ready) begin
            if (exp_q.size() == 0) begin
               chk("tx_unexpected", {23'd0, tx_a.o_tx_dc, tx_a.o_tx_byte}, 32'h1ff);
            end else begin
               e = exp_q.pop_front();
               chk("tx_byte", {23'd0, tx_a.o_tx_dc, tx_a.o_tx_byte}, {23'd0, e});
            end
            in_gap  = 1'b1;
            gap_cnt = 0;
         end
      end else if (!busy) begin
         in_gap = 1'b0;
      end else if (in_gap) begin
         gap_cnt++;
      end
      if (rena) ena_cnt++;
      if (rval !== (busy ? 1'b0 : 1'b1)) val_bad++;
      if (prev_done) chk("busy_after_done", {31'd0, busy}, 32'd0);
      if (done) begin
         done_cnt++;
         chk("busy_at_done", {31'd0, busy}, 32'd1);
      end
      prev_done = done;
   end

   always @(negedge clk) begin : mon_b
      if (tx_b.o_tx_valid) b_q.push_back({tx_b.o_tx_dc, tx_b.o_tx_byte});
      if (done_b) b_done++;
      if (rena_b) b_ena++;
      if (rval_b !== (busy_b ? 1'b0 : 1'b1)) b_val_bad++;
   end

   task automatic check_reset_outs(input string tag);
      chk({tag, "_busy"},  {31'd0, busy}, 32'd0);
      chk({tag, "_done"},  {31'd0, done}, 32'd0);
      chk({tag, "_rena"},  {31'd0, rena}, 32'd0);
      chk({tag, "_rval"},  {31'd0, rval}, 32'd1);
      chk({tag, "_valid"}, {31'd0, tx_a.o_tx_valid}, 32'd0);
      chk({tag, "_byte"},  {24'd0, tx_a.o_tx_byte}, 32'd0);
      chk({tag, "_dc"},    {31'd0, tx_a.o_tx_dc}, 32'd0);
   endtask

   task automatic clear_run();
      ena_cnt  = 0;
      val_bad  = 0;
      done_cnt = 0;
      gap_q.delete();
      exp_q.delete();
   endtask

   task automatic push_seq();
      exp_q.push_back({1'b0, 8'h01});
      exp_q.push_back({1'b0, 8'h11});
      exp_q.push_back({1'b0, 8'h3A});
      exp_q.push_back({1'b1, 8'h55});
   endtask

   task automatic start_pulse();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic sent_after(input int n);
      repeat (n - 1) @(posedge clk);
      #1 sent = 1'b1;
      @(posedge clk); #1 sent = 1'b0;
   endtask

   task automatic wait_done();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (done) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic end_run(input string tag);
      repeat (3) @(posedge clk);
      #1;
      chk({tag, "_reset_ena_pulses"}, ena_cnt, 32'd1);
      chk({tag, "_reset_val_level"}, val_bad, 32'd0);
      chk({tag, "_done_pulses"}, done_cnt, 32'd1);
      chk({tag, "_queue_left"}, exp_q.size(), 32'd0);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : stim
      int gap_exp[3];
      logic [9:0] snap;
      int idle_busy;
      bit seen;
      gap_exp = '{3 * CPM + 2, 3, 1};

      repeat (3) @(posedge clk);
      #1 check_reset_outs("in_reset");
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 check_reset_outs("after_reset");

      // Run 1: full short table, delay corners, ROM_DEPTH boundary on dut_b
      clear_run();
      push_seq();
      start_pulse();
      sent_after(10);
      wait_done();
      end_run("run1");
      chk("gap_count", gap_q.size(), 32'd3);
      for (int i = 0; i < 3; i++) begin
         if (i < gap_q.size()) chk($sformatf("gap_%0d", i), gap_q[i], gap_exp[i]);
      end
      chk("b_tx_count", b_q.size(), 32'd2);
      if (b_q.size() >= 2) begin
         chk("b_tx0", {23'd0, b_q[0]}, {23'd0, 1'b0, 8'h01});
         chk("b_tx1", {23'd0, b_q[1]}, {23'd0, 1'b0, 8'h11});
      end
      chk("b_done_pulses", b_done, 32'd1);
      chk("b_reset_ena_pulses", b_ena, 32'd1);
      chk("b_reset_val_level", b_val_bad, 32'd0);

      // Run 2: sender stalls the first byte for 7 cycles
      clear_run();
      push_seq();
      ready = 1'b0;
      start_pulse();
      sent_after(10);
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (tx_a.o_tx_valid) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) chk("stall_valid_timeout", 32'd0, 32'd1);
      snap = {tx_a.o_tx_valid, tx_a.o_tx_dc, tx_a.o_tx_byte};
      chk("stall_first", {22'd0, snap}, {22'd0, 1'b1, 1'b0, 8'h01});
      repeat (6) begin
         @(negedge clk);
         chk("stall_hold", {22'd0, tx_a.o_tx_valid, tx_a.o_tx_dc, tx_a.o_tx_byte}, {22'd0, snap});
      end
      @(posedge clk); #1 ready = 1'b1;
      wait_done();
      end_run("run2");

      // Run 3: reset asserted inside the 3 ms delay
      clear_run();
      push_seq();
      start_pulse();
      sent_after(10);
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (tx_a.o_tx_valid && ready) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) chk("abort_tx_timeout", 32'd0, 32'd1);
      repeat (4) @(posedge clk);
      #1 rst = 1'b0;
      #1 check_reset_outs("async_reset");
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      idle_busy = 0;
      repeat (20) begin
         @(negedge clk);
         if (busy) idle_busy++;
      end
      chk("no_restart_after_reset", idle_busy, 32'd0);
      clear_run();
      push_seq();
      start_pulse();
      sent_after(10);
      wait_done();
      end_run("run3");

      // Run 4: start while busy and during the done cycle
      clear_run();
      push_seq();
      start_pulse();
      repeat (2) @(posedge clk);
      start_pulse();
      sent_after(7);
      wait_done();
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      idle_busy = 0;
      repeat (30) begin
         @(negedge clk);
         if (busy) idle_busy++;
      end
      chk("ignored_start_busy", idle_busy, 32'd0);
      end_run("run4");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
